uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_fifo.sv | 61 ++++++
 rtl/uart_rx_ctrl.sv | 157 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM encodings, CPU and
// receiver register maps, and status bit positions.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_STAT = 2'd1,
      RD_DATA = 2'd2,
      PUSH    = 2'd3
   } rx_state_t;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_UOV   = 2;
   localparam int ST_FOV   = 3;

   localparam int CTRL_IEN = 0;

   localparam int RX_DA = 0;
   localparam int RX_OV = 1;

   localparam logic RX_ADDR_DATA   = 1'b0;
   localparam logic RX_ADDR_STATUS = 1'b1;

   function automatic logic [7:0] pack_status(input logic fov, input logic uov,
                                              input logic full, input logic empty);
      logic [7:0] s;
      s           = 8'h00;
      s[ST_FOV]   = fov;
      s[ST_UOV]   = uov;
      s[ST_FULL]  = full;
      s[ST_EMPTY] = empty;
      return s;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO for received UART data; power-of-two depth so pointers wrap for free.
module uart_fifo #(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_push,
   input  logic [7:0]    i_data,
   input  logic          i_pop,
   output logic [7:0]    o_head,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign o_full  = (count == FULL_COUNT);
   assign o_empty = (count == '0);
   assign o_count = count;
   assign o_head  = mem[rd_ptr];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign pop_ok  = i_pop && !o_empty;
   assign push_ok = i_push && (!o_full || pop_ok);

   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: drains the receiver over its register bus into a
// FIFO and exposes FIFO, sticky error flags and interrupt enable to the CPU.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic [1:0] i_addr,
   input  logic       i_cyc,
   input  logic       i_we,
   input  logic [7:0] i_dat,
   output logic [7:0] o_dat,
   output logic       o_int,
   output logic       m_cyc,
   output logic       m_addr,
   output logic       m_we,
   input  logic [7:0] i_mdat,
   input  logic       i_uart_int
);

   localparam int CW = $clog2(DEPTH) + 1;

   rx_state_t     state_q;
   rx_state_t     state_d;
   logic          pend_q;
   logic [7:0]    hold_q;
   logic          fov_q;
   logic          uov_q;
   logic          ien_q;
   logic          int_q;

   logic          cpu_rd;
   logic          cpu_wr;
   logic          stat_wr;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_head;
   logic [CW-1:0] fifo_count;
   logic          fov_set;
   logic          uov_set;
   logic          unused_dat;

   assign cpu_rd   = i_cyc && !i_we;
   assign cpu_wr   = i_cyc && i_we;
   assign stat_wr  = cpu_wr && (i_addr == REG_STATUS);
   assign fifo_pop = cpu_rd && (i_addr == REG_DATA) && !fifo_empty;

   assign fifo_push = (state_q == PUSH) && (!fifo_full || fifo_pop);
   assign fov_set   = (state_q == PUSH) && fifo_full && !fifo_pop;
   assign uov_set   = (state_q == RD_STAT) && i_mdat[RX_OV];

   assign m_we       = 1'b0;
   assign o_int      = int_q;
   assign unused_dat = ^{i_dat[7:4], i_dat[1]};

   uart_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_push    (fifo_push),
      .i_data    (hold_q),
      .i_pop     (fifo_pop),
      .o_head    (fifo_head),
      .o_full    (fifo_full),
      .o_empty   (fifo_empty),
      .o_count   (fifo_count)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Bus strobes depend on the state register alone, never on i_mdat.
   always_comb begin
      state_d = state_q;
      m_cyc   = 1'b0;
      m_addr  = RX_ADDR_DATA;
      case (state_q)
         IDLE: begin
            if (i_uart_int || pend_q) begin
               state_d = RD_STAT;
            end
         end
         RD_STAT: begin
            m_cyc   = 1'b1;
            m_addr  = RX_ADDR_STATUS;
            state_d = i_mdat[RX_DA] ? RD_DATA : IDLE;
         end
         RD_DATA: begin
            m_cyc   = 1'b1;
            m_addr  = RX_ADDR_DATA;
            state_d = PUSH;
         end
         PUSH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A receive pulse seen mid-transaction is remembered and replayed from IDLE.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pend_q <= 1'b0;
         hold_q <= 8'h00;
      end else begin
         if (state_q == IDLE) begin
            if (state_d == RD_STAT) begin
               pend_q <= 1'b0;
            end
         end else if (i_uart_int) begin
            pend_q <= 1'b1;
         end
         if (state_q == RD_DATA) begin
            hold_q <= i_mdat;
         end
      end
   end

   // Sticky flags: a new error in the same cycle as a W1C clear keeps the flag set.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         fov_q <= 1'b0;
         uov_q <= 1'b0;
         ien_q <= 1'b0;
         int_q <= 1'b0;
      end else begin
         fov_q <= fov_set || (fov_q && !(stat_wr && i_dat[ST_FOV]));
         uov_q <= uov_set || (uov_q && !(stat_wr && i_dat[ST_UOV]));
         if (cpu_wr && (i_addr == REG_CTRL)) begin
            ien_q <= i_dat[CTRL_IEN];
         end
         int_q <= ien_q && !fifo_empty;
      end
   end

   always_comb begin
      o_dat = 8'h00;
      case (i_addr)
         REG_DATA:   o_dat = fifo_empty ? 8'h00 : fifo_head;
         REG_STATUS: o_dat = pack_status(fov_q, uov_q, fifo_full, fifo_empty);
         REG_COUNT:  o_dat = {{(8-CW){1'b0}}, fifo_count};
         REG_CTRL:   o_dat = {7'b0, ien_q};
         default:    o_dat = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: vector table, directed corner cases and
// randomized traffic against a queue-based model of the FIFO and flags.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 8;
   localparam int K_RX = 0;
   localparam int K_RD = 1;
   localparam int K_WR = 2;

   typedef struct {
      int         kind;
      logic [1:0] addr;
      logic [7:0] data;
      logic       ov;
      logic [7:0] exp;
   } vec_t;

   logic       i_clk = 1'b0;
   logic       i_reset_n;
   logic [1:0] i_addr;
   logic       i_cyc;
   logic       i_we;
   logic [7:0] i_dat;
   logic [7:0] o_dat;
   logic       o_int;
   logic       m_cyc;
   logic       m_addr;
   logic       m_we;
   logic [7:0] i_mdat;
   logic       i_uart_int;

   logic       rx_da;
   logic       rx_ov;
   logic [7:0] rx_byte;

   int         checks = 0;
   int         errors = 0;
   vec_t       vecs[$];
   logic [7:0] rd;

   logic [7:0] mq[$];
   logic       m_fov;
   logic       m_uov;
   logic       m_ien;

   always #5 i_clk = ~i_clk;

   uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_addr     (i_addr),
      .i_cyc      (i_cyc),
      .i_we       (i_we),
      .i_dat      (i_dat),
      .o_dat      (o_dat),
      .o_int      (o_int),
      .m_cyc      (m_cyc),
      .m_addr     (m_addr),
      .m_we       (m_we),
      .i_mdat     (i_mdat),
      .i_uart_int (i_uart_int)
   );

   // Receiver: status at address 1, byte at address 0.
   assign i_mdat = !m_cyc ? 8'h00 : (m_addr ? {6'b0, rx_ov, rx_da} : rx_byte);

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
      end
   endtask

   // One clock; a completed receiver data read clears DA/OV like the real receiver.
   task automatic step();
      logic data_rd;
      data_rd = m_cyc && !m_addr;
      @(posedge i_clk);
      #1;
      if (data_rd) begin
         rx_da = 1'b0;
         rx_ov = 1'b0;
      end
   endtask

   task automatic cpuAccess(input logic [1:0] addr, input logic we, input logic [7:0] data,
                            output logic [7:0] rdata);
      i_cyc  = 1'b1;
      i_addr = addr;
      i_we   = we;
      i_dat  = data;
      #1;
      rdata = o_dat;
      step();
      i_cyc = 1'b0;
      i_we  = 1'b0;
      i_dat = 8'h00;
   endtask

   task automatic rxByte(input logic [7:0] b, input logic ov);
      rx_byte    = b;
      rx_ov      = ov || rx_da;
      rx_da      = 1'b1;
      i_uart_int = 1'b1;
      step();
      i_uart_int = 1'b0;
      checkOutput("rx_c1_bus", {6'b0, m_cyc, m_addr}, 8'h03);
      step();
      checkOutput("rx_c2_bus", {6'b0, m_cyc, m_addr}, 8'h02);
      step();
      checkOutput("rx_c3_bus", {6'b0, m_cyc, m_addr}, 8'h00);
      step();
   endtask

   task automatic addVec(input int kind, input logic [1:0] addr, input logic [7:0] data,
                         input logic ov, input logic [7:0] exp);
      vec_t v;
      v.kind = kind;
      v.addr = addr;
      v.data = data;
      v.ov   = ov;
      v.exp  = exp;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      logic [7:0] r;
      case (v.kind)
         K_RX: rxByte(v.data, v.ov);
         K_RD: begin
            cpuAccess(v.addr, 1'b0, 8'h00, r);
            checkOutput($sformatf("vec%0d_rd_a%0d", idx, v.addr), r, v.exp);
         end
         default: cpuAccess(v.addr, 1'b1, v.data, r);
      endcase
   endtask

   function automatic logic [7:0] modelStatus();
      return {4'b0, m_fov, m_uov, (mq.size() == DEPTH), (mq.size() == 0)};
   endfunction

   initial begin
      i_reset_n  = 1'b0;
      i_addr     = 2'd0;
      i_cyc      = 1'b0;
      i_we       = 1'b0;
      i_dat      = 8'h00;
      i_uart_int = 1'b0;
      rx_da      = 1'b0;
      rx_ov      = 1'b0;
      rx_byte    = 8'h00;

      #2;
      checkOutput("reset_m_cyc", {7'b0, m_cyc}, 8'h00);
      checkOutput("reset_m_we", {7'b0, m_we}, 8'h00);
      checkOutput("reset_o_int", {7'b0, o_int}, 8'h00);
      i_addr = 2'd1;
      #1;
      checkOutput("reset_status", o_dat, 8'h01);
      i_addr = 2'd2;
      #1;
      checkOutput("reset_count", o_dat, 8'h00);
      i_addr = 2'd0;
      i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;

      addVec(K_RX, 2'd0, 8'hA5, 1'b0, 8'h00);
      addVec(K_RD, 2'd2, 8'h00, 1'b0, 8'h01);
      addVec(K_RD, 2'd1, 8'h00, 1'b0, 8'h00);
      addVec(K_RD, 2'd0, 8'h00, 1'b0, 8'hA5);
      addVec(K_RD, 2'd1, 8'h00, 1'b0, 8'h01);
      addVec(K_RD, 2'd0, 8'h00, 1'b0, 8'h00);
      addVec(K_RX, 2'd0, 8'h3C, 1'b1, 8'h00);
      addVec(K_RD, 2'd1, 8'h00, 1'b0, 8'h04);
      addVec(K_WR, 2'd1, 8'h04, 1'b0, 8'h00);
      addVec(K_RD, 2'd1, 8'h00, 1'b0, 8'h00);
      addVec(K_WR, 2'd3, 8'h01, 1'b0, 8'h00);
      addVec(K_RD, 2'd3, 8'h00, 1'b0, 8'h01);
      addVec(K_WR, 2'd0, 8'hFF, 1'b0, 8'h00);
      addVec(K_WR, 2'd2, 8'hFF, 1'b0, 8'h00);
      addVec(K_RD, 2'd2, 8'h00, 1'b0, 8'h01);
      addVec(K_RD, 2'd0, 8'h00, 1'b0, 8'h3C);
      addVec(K_WR, 2'd3, 8'h00, 1'b0, 8'h00);
      addVec(K_RD, 2'd3, 8'h00, 1'b0, 8'h00);
      for (int i = 0; i < 9; i++) addVec(K_RX, 2'd0, 8'h10 + 8'(i), 1'b0, 8'h00);
      addVec(K_RD, 2'd1, 8'h00, 1'b0, 8'h0A);
      addVec(K_RD, 2'd2, 8'h00, 1'b0, 8'h08);
      for (int i = 0; i < 8; i++) addVec(K_RD, 2'd0, 8'h00, 1'b0, 8'h10 + 8'(i));
      addVec(K_RD, 2'd1, 8'h00, 1'b0, 8'h09);
      addVec(K_RD, 2'd2, 8'h00, 1'b0, 8'h00);
      addVec(K_RX, 2'd0, 8'h55, 1'b1, 8'h00);
      addVec(K_RD, 2'd1, 8'h00, 1'b0, 8'h0C);
      addVec(K_WR, 2'd1, 8'h04, 1'b0, 8'h00);
      addVec(K_RD, 2'd1, 8'h00, 1'b0, 8'h08);
      addVec(K_WR, 2'd1, 8'h08, 1'b0, 8'h00);
      addVec(K_RD, 2'd1, 8'h00, 1'b0, 8'h00);
      addVec(K_RD, 2'd0, 8'h00, 1'b0, 8'h55);
      addVec(K_RD, 2'd1, 8'h00, 1'b0, 8'h01);

      foreach (vecs[i]) applyStimulus(i, vecs[i]);

      // Interrupt follows IEN & ~EMPTY one cycle late.
      cpuAccess(2'd3, 1'b1, 8'h01, rd);
      rxByte(8'h77, 1'b0);
      checkOutput("int_same_cycle", {7'b0, o_int}, 8'h00);
      step();
      checkOutput("int_set", {7'b0, o_int}, 8'h01);
      cpuAccess(2'd0, 1'b0, 8'h00, rd);
      checkOutput("int_pop_data", rd, 8'h77);
      checkOutput("int_pop_cycle", {7'b0, o_int}, 8'h01);
      step();
      checkOutput("int_clear", {7'b0, o_int}, 8'h00);
      cpuAccess(2'd3, 1'b1, 8'h00, rd);
      rxByte(8'h88, 1'b0);
      step();
      step();
      checkOutput("int_disabled", {7'b0, o_int}, 8'h00);
      cpuAccess(2'd0, 1'b0, 8'h00, rd);
      checkOutput("int_dis_data", rd, 8'h88);

      // Spurious interrupt: DA=0 returns to IDLE after one status read.
      i_uart_int = 1'b1;
      step();
      i_uart_int = 1'b0;
      checkOutput("spur_c1_bus", {6'b0, m_cyc, m_addr}, 8'h03);
      step();
      checkOutput("spur_c2_bus", {6'b0, m_cyc, m_addr}, 8'h00);
      step();
      cpuAccess(2'd2, 1'b0, 8'h00, rd);
      checkOutput("spur_count", rd, 8'h00);

      // Second pulse during PUSH is replayed from IDLE.
      rx_byte = 8'hC1; rx_da = 1'b1; rx_ov = 1'b0;
      i_uart_int = 1'b1;
      step();
      i_uart_int = 1'b0;
      step();
      step();
      rx_byte = 8'hC2; rx_da = 1'b1;
      i_uart_int = 1'b1;
      step();
      i_uart_int = 1'b0;
      checkOutput("pend_c4_bus", {6'b0, m_cyc, m_addr}, 8'h00);
      step();
      checkOutput("pend_c5_bus", {6'b0, m_cyc, m_addr}, 8'h03);
      step();
      checkOutput("pend_c6_bus", {6'b0, m_cyc, m_addr}, 8'h02);
      step();
      step();
      cpuAccess(2'd2, 1'b0, 8'h00, rd);
      checkOutput("pend_count", rd, 8'h02);
      cpuAccess(2'd0, 1'b0, 8'h00, rd);
      checkOutput("pend_byte0", rd, 8'hC1);
      cpuAccess(2'd0, 1'b0, 8'h00, rd);
      checkOutput("pend_byte1", rd, 8'hC2);

      // Full FIFO with a pop in the PUSH cycle accepts the new byte.
      for (int i = 0; i < DEPTH; i++) rxByte(8'h20 + 8'(i), 1'b0);
      cpuAccess(2'd1, 1'b0, 8'h00, rd);
      checkOutput("full_status", rd, 8'h02);
      rx_byte = 8'h99; rx_da = 1'b1; rx_ov = 1'b0;
      i_uart_int = 1'b1;
      step();
      i_uart_int = 1'b0;
      step();
      step();
      cpuAccess(2'd0, 1'b0, 8'h00, rd);
      checkOutput("full_pop_data", rd, 8'h20);
      cpuAccess(2'd2, 1'b0, 8'h00, rd);
      checkOutput("full_pop_count", rd, 8'h08);
      cpuAccess(2'd1, 1'b0, 8'h00, rd);
      checkOutput("full_pop_status", rd, 8'h02);
      for (int i = 1; i < DEPTH; i++) begin
         cpuAccess(2'd0, 1'b0, 8'h00, rd);
         checkOutput($sformatf("full_drain%0d", i), rd, 8'h20 + 8'(i));
      end
      cpuAccess(2'd0, 1'b0, 8'h00, rd);
      checkOutput("full_new_byte", rd, 8'h99);

      // Reset during RD_DATA aborts the transfer.
      cpuAccess(2'd3, 1'b1, 8'h01, rd);
      rxByte(8'h44, 1'b0);
      step();
      checkOutput("rst_pre_int", {7'b0, o_int}, 8'h01);
      rx_byte = 8'h45; rx_da = 1'b1; rx_ov = 1'b0;
      i_uart_int = 1'b1;
      step();
      i_uart_int = 1'b0;
      step();
      checkOutput("rst_pre_bus", {6'b0, m_cyc, m_addr}, 8'h02);
      i_reset_n = 1'b0;
      #1;
      checkOutput("rst_m_cyc", {7'b0, m_cyc}, 8'h00);
      checkOutput("rst_o_int", {7'b0, o_int}, 8'h00);
      i_addr = 2'd2;
      #1;
      checkOutput("rst_count", o_dat, 8'h00);
      i_addr = 2'd3;
      #1;
      checkOutput("rst_ien", o_dat, 8'h00);
      i_addr = 2'd0;
      i_reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput($sformatf("rst_idle%0d", i), {7'b0, m_cyc}, 8'h00);
      end
      cpuAccess(2'd2, 1'b0, 8'h00, rd);
      checkOutput("rst_post_count", rd, 8'h00);
      rx_da = 1'b0;
      rx_ov = 1'b0;

      // Randomized traffic against the queue model.
      mq.delete();
      m_fov = 1'b0;
      m_uov = 1'b0;
      m_ien = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 9) < 4) begin
            logic [7:0] b;
            logic       ov;
            b  = 8'($urandom);
            ov = ($urandom_range(0, 7) == 0);
            rxByte(b, ov);
            if (ov) m_uov = 1'b1;
            if (mq.size() < DEPTH) mq.push_back(b);
            else m_fov = 1'b1;
         end else begin
            logic [1:0] a;
            logic       we;
            logic [7:0] d;
            logic [7:0] exp;
            a  = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            case (a)
               2'd0:    exp = (mq.size() == 0) ? 8'h00 : mq[0];
               2'd1:    exp = modelStatus();
               2'd2:    exp = 8'(mq.size());
               default: exp = {7'b0, m_ien};
            endcase
            cpuAccess(a, we, d, rd);
            if (!we) begin
               checkOutput($sformatf("rand%0d_rd_a%0d", n, a), rd, exp);
               if (a == 2'd0 && mq.size() != 0) void'(mq.pop_front());
            end else if (a == 2'd1) begin
               if (d[3]) m_fov = 1'b0;
               if (d[2]) m_uov = 1'b0;
            end else if (a == 2'd3) begin
               m_ien = d[0];
            end
         end
         step();
         checkOutput($sformatf("rand%0d_int", n), {7'b0, o_int},
                     {7'b0, (m_ien && mq.size() != 0)});
      end
      cpuAccess(2'd1, 1'b0, 8'h00, rd);
      checkOutput("rand_final_status", rd, modelStatus());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
